// File: rtl/pcpu_pkg.sv
// Shared processor types: architectural register view and register-dump streamer definitions.
package pcpu;

  // Field order follows x0..x31, so zero lands in the most significant word.
  typedef struct packed {
    logic [31:0] zero, ra, sp, gp, tp, t0, t1, t2;
    logic [31:0] s0, s1, a0, a1, a2, a3, a4, a5;
    logic [31:0] a6, a7, s2, s3, s4, s5, s6, s7;
    logic [31:0] s8, s9, s10, s11, t3, t4, t5, t6;
  } RV32_Regs_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } reg_dump_state_t;

  localparam logic [5:0] REG_DUMP_CSUM_IDX = 6'd32;

endpackage

// File: rtl/regs_struct_to_array.sv
// Pure wiring: lays the named register struct out as an array indexed by register number.
module regs_struct_to_array
  import pcpu::*;
(
  input  RV32_Regs_t  regs_i,
  output logic [31:0] arr_o [32]
);

  assign arr_o[0]  = regs_i.zero;
  assign arr_o[1]  = regs_i.ra;
  assign arr_o[2]  = regs_i.sp;
  assign arr_o[3]  = regs_i.gp;
  assign arr_o[4]  = regs_i.tp;
  assign arr_o[5]  = regs_i.t0;
  assign arr_o[6]  = regs_i.t1;
  assign arr_o[7]  = regs_i.t2;
  assign arr_o[8]  = regs_i.s0;
  assign arr_o[9]  = regs_i.s1;
  assign arr_o[10] = regs_i.a0;
  assign arr_o[11] = regs_i.a1;
  assign arr_o[12] = regs_i.a2;
  assign arr_o[13] = regs_i.a3;
  assign arr_o[14] = regs_i.a4;
  assign arr_o[15] = regs_i.a5;
  assign arr_o[16] = regs_i.a6;
  assign arr_o[17] = regs_i.a7;
  assign arr_o[18] = regs_i.s2;
  assign arr_o[19] = regs_i.s3;
  assign arr_o[20] = regs_i.s4;
  assign arr_o[21] = regs_i.s5;
  assign arr_o[22] = regs_i.s6;
  assign arr_o[23] = regs_i.s7;
  assign arr_o[24] = regs_i.s8;
  assign arr_o[25] = regs_i.s9;
  assign arr_o[26] = regs_i.s10;
  assign arr_o[27] = regs_i.s11;
  assign arr_o[28] = regs_i.t3;
  assign arr_o[29] = regs_i.t4;
  assign arr_o[30] = regs_i.t5;
  assign arr_o[31] = regs_i.t6;

endmodule

// File: rtl/reg_dump_streamer.sv
// Snapshots the register file on start and streams x0..x31 (plus optional XOR checksum) over valid/ready.
// Define REG_DUMP_SKIP_ZERO_EN to drop zero-valued registers from the stream (checksum word always sent).
module reg_dump_streamer
  import pcpu::*;
#(
  parameter int INCLUDE_CHECKSUM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  RV32_Regs_t  regs_in,
  input  logic        start,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  // Skipping can remove register 31, so the checksum word must carry out_last.
  localparam bit CSUM_EN = 1'b1 | (INCLUDE_CHECKSUM != 0);
`else
  localparam bit CSUM_EN = (INCLUDE_CHECKSUM != 0);
`endif

  reg_dump_state_t state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     csum_q, csum_d;
  logic [31:0]     snap_q [32];
  logic [31:0]     live_arr [32];
  logic [31:0]     cur_word;
  logic            snap_we;
  logic            advance;

  regs_struct_to_array u_map (
    .regs_i (regs_in),
    .arr_o  (live_arr)
  );

  assign cur_word = snap_q[idx_q[4:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) snap_q[i] <= '0;
    end else if (snap_we) begin
      snap_q <= live_arr;
    end
  end

  // Outputs depend only on state and registered data, never on out_ready.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    snap_we   = 1'b0;
    advance   = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          snap_we = 1'b1;
          idx_d   = '0;
          csum_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        out_idx  = idx_q;
        out_data = cur_word;
        out_last = !CSUM_EN && (idx_q == 6'd31);
`ifdef REG_DUMP_SKIP_ZERO_EN
        if (cur_word == '0) begin
          advance = 1'b1;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            csum_d  = csum_q ^ cur_word;
            advance = 1'b1;
          end
        end
`else
        out_valid = 1'b1;
        if (out_ready) begin
          csum_d  = csum_q ^ cur_word;
          advance = 1'b1;
        end
`endif
        if (advance) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd31) state_d = CSUM_EN ? CSUM : DONE;
        end
      end

      CSUM: begin
        out_valid = 1'b1;
        out_idx   = REG_DUMP_CSUM_IDX;
        out_data  = csum_q;
        out_last  = 1'b1;
        if (out_ready) state_d = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
